scroll_tick_gen: RTL

//  Pacing source for the tile offset counter. Emits one-cycle offset_increase

---
 rtl/scroll_tick_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: paces offset steps and row-edge strobes for the tile offset counter; SCROLL_RAMP_EN enables the difficulty ramp
module scroll_tick_gen #(
    parameter int                 DIV_W      = 26,
    parameter logic [DIV_W-1:0]   DIV_START  = 26'd2500000,
    parameter logic [DIV_W-1:0]   DIV_MIN    = 26'd500000,
    parameter logic [DIV_W-1:0]   DIV_STEP   = 26'd250000,
    parameter logic [5:0]         EDGE_COUNT = 6'd60,
    parameter logic [3:0]         RAMP_EDGES = 4'd4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             startn,
    input  logic             pause,
    input  logic             game_over,
    output logic             offset_increase,
    output logic             edge_go,
    output logic             busy,
    output logic [3:0]       speed_level,
    output logic [DIV_W-1:0] cur_div
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [DIV_W-1:0] ONE = 1;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [5:0]       tick_q, tick_d;
    logic             inc_q, inc_d, edge_q, edge_d;
    logic             active;
`ifdef SCROLL_RAMP_EN
    logic [DIV_W-1:0] div_q, div_d, div_nx;
    logic [3:0]       lvl_q, lvl_d, edges_q, edges_d;
    // Next ramp period, clamped to DIV_MIN without wrapping below zero
    assign div_nx = ({1'b0, div_q} >= ({1'b0, DIV_MIN} + {1'b0, DIV_STEP})) ? div_q - DIV_STEP : DIV_MIN;
    assign speed_level = lvl_q;
`else
    logic [DIV_W-1:0] div_q;
    logic             unused_ramp;
    assign div_q       = DIV_START;
    assign speed_level = 4'd0;
    assign unused_ramp = ^{DIV_MIN, DIV_STEP, RAMP_EDGES};
`endif
    assign active          = (state_q == RUN) || (state_q == PAUSE);
    assign busy            = active;
    assign offset_increase = inc_q;
    assign edge_go         = edge_q;
    assign cur_div         = div_q;
    // Next state: start from IDLE/DONE, game_over beats pause, pause beats a due strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        inc_d   = 1'b0;
        edge_d  = 1'b0;
`ifdef SCROLL_RAMP_EN
        div_d   = div_q;
        lvl_d   = lvl_q;
        edges_d = edges_q;
`endif
        if (!active) begin
            if (!startn) begin
                state_d = RUN;
                cnt_d   = DIV_START - ONE;
                tick_d  = 6'd0;
`ifdef SCROLL_RAMP_EN
                div_d   = DIV_START;
                lvl_d   = 4'd0;
                edges_d = 4'd0;
`endif
            end
        end else if (game_over) begin
            state_d = DONE;
        end else if (pause) begin
            state_d = PAUSE;
        end else begin
            state_d = RUN;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - ONE;
            end else begin
                cnt_d = div_q - ONE;
                if (tick_q != EDGE_COUNT - 6'd1) begin
                    inc_d  = 1'b1;
                    tick_d = tick_q + 6'd1;
                end else begin
                    edge_d = 1'b1;
                    tick_d = 6'd0;
`ifdef SCROLL_RAMP_EN
                    if (edges_q + 4'd1 == RAMP_EDGES) begin
                        edges_d = 4'd0;
                        div_d   = div_nx;
                        cnt_d   = div_nx - ONE;
                        lvl_d   = (lvl_q == 4'd15) ? lvl_q : lvl_q + 4'd1;
                    end else begin
                        edges_d = edges_q + 4'd1;
                    end
`endif
                end
            end
        end
    end
    // State, counters and registered strobes with async reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= '0;
            inc_q   <= 1'b0;
            edge_q  <= 1'b0;
`ifdef SCROLL_RAMP_EN
            div_q   <= DIV_START;
            lvl_q   <= '0;
            edges_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            inc_q   <= inc_d;
            edge_q  <= edge_d;
`ifdef SCROLL_RAMP_EN
            div_q   <= div_d;
            lvl_q   <= lvl_d;
            edges_q <= edges_d;
`endif
        end
    end
endmodule
